// File: rtl/div_sequencer.sv
// div_sequencer: accepts one divide request at a time, launches a multi-cycle divider,
// and returns its result with divide-by-zero and timeout flags.
module div_sequencer #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_divs,
    output logic        div_remainder,
    output logic        div_go,
    input  logic [31:0] div_c,
    input  logic        div_is_zero,
    input  logic        div_is_negative,
    input  logic        div_available,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_negative,
    output logic        rsp_dz,
    output logic        rsp_timeout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] a_q, b_q, data_q;
    logic        divs_q, rem_q, go_q, vld_q, zero_q, neg_q, dz_q, to_q;

    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign div_divs      = divs_q;
    assign div_remainder = rem_q;
    assign div_go        = go_q;
    assign rsp_valid     = vld_q;
    assign rsp_data      = data_q;
    assign rsp_zero      = zero_q;
    assign rsp_negative  = neg_q;
    assign rsp_dz        = dz_q;
    assign rsp_timeout   = to_q;

    // Operands hold from acceptance through RESP: the divider's sign fix-up reads them live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            divs_q  <= 1'b0;
            rem_q   <= 1'b0;
            go_q    <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    a_q     <= req_a;
                    b_q     <= req_b;
                    divs_q  <= req_op[1];
                    rem_q   <= req_op[0];
                    go_q    <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    go_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (div_available) begin
                    data_q  <= div_c;
                    zero_q  <= div_is_zero;
                    neg_q   <= div_is_negative;
                    dz_q    <= (b_q == '0);
                    to_q    <= 1'b0;
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end else if (cnt_q == TERM) begin
                    data_q  <= '0;
                    zero_q  <= 1'b1;
                    neg_q   <= 1'b0;
                    dz_q    <= (b_q == '0);
                    to_q    <= 1'b1;
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
                RESP: if (rsp_ready) begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of div_sequencer against hand-computed results,
// with a small stand-in divider that answers when the bench pulses div_available.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_op;
    logic [31:0] div_a, div_b, div_c;
    logic        div_divs, div_remainder, div_go;
    logic        div_is_zero, div_is_negative, div_available;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_negative, rsp_dz, rsp_timeout, busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_a, cur_b;
    logic [1:0]  cur_op;

    always #5 clk = ~clk;

    div_sequencer #(.TIMEOUT(100)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .div_a(div_a), .div_b(div_b), .div_divs(div_divs), .div_remainder(div_remainder),
        .div_go(div_go), .div_c(div_c), .div_is_zero(div_is_zero),
        .div_is_negative(div_is_negative), .div_available(div_available),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_zero(rsp_zero), .rsp_negative(rsp_negative), .rsp_dz(rsp_dz),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Stand-in divider: quotient 0 and remainder = dividend on a zero divisor.
    function automatic logic [32:0] divider(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [31:0] r;
        if (b == 0)
            r = op[0] ? a : 32'd0;
        else if (op[1])
            r = op[0] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else
            r = op[0] ? a % b : a / b;
        return {op[1] & r[31], r};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        cur_a = a; cur_b = b; cur_op = op;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_a = a; req_b = b; req_op = op;
        @(negedge clk);
        req_valid = 0; req_a = '0; req_b = '0; req_op = '0;
        chk("go_issue", div_go, 1);
        chk("req_ready_issue", req_ready, 0);
        chk("busy_issue", busy, 1);
        chk("div_a", div_a, a);
        chk("div_b", div_b, b);
        chk("div_divs", div_divs, op[1]);
        chk("div_remainder", div_remainder, op[0]);
        @(negedge clk);
        chk("go_one_cycle", div_go, 0);
    endtask

    task automatic respond(input int hold, input logic [31:0] exp_data);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, exp_data);
            chk("hold_div_a", div_a, cur_a);
            chk("hold_div_b", div_b, cur_b);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("valid_drop", rsp_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic complete(input int dly, input int hold, input logic [31:0] exp_data,
                            input logic exp_zero, input logic exp_neg, input logic exp_dz);
        logic [32:0] r;
        repeat (dly) @(negedge clk);
        chk("no_early_valid", rsp_valid, 0);
        r = divider(cur_a, cur_b, cur_op);
        div_c = r[31:0]; div_is_zero = (r[31:0] == 0); div_is_negative = r[32];
        div_available = 1;
        @(negedge clk);
        div_available = 0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_zero", rsp_zero, exp_zero);
        chk("rsp_negative", rsp_negative, exp_neg);
        chk("rsp_dz", rsp_dz, exp_dz);
        chk("rsp_timeout", rsp_timeout, 0);
        respond(hold, exp_data);
    endtask

    initial begin
        logic early;
        rst_n = 0; req_valid = 0; req_a = '0; req_b = '0; req_op = '0;
        div_c = '0; div_is_zero = 0; div_is_negative = 0; div_available = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_go", div_go, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst_n = 1;

        start(32'd100, 32'd7, 2'b00); complete(3, 0, 32'd14, 0, 0, 0);
        start(32'd100, 32'd7, 2'b01); complete(0, 0, 32'd2, 0, 0, 0);
        start(32'hFFFF_FFF9, 32'd2, 2'b10); complete(5, 0, 32'hFFFF_FFFD, 0, 1, 0);
        start(32'hFFFF_FFF9, 32'd2, 2'b11); complete(2, 0, 32'hFFFF_FFFF, 0, 1, 0);
        start(32'd5, 32'd0, 2'b00); complete(1, 0, 32'd0, 1, 0, 1);
        start(32'd5, 32'd0, 2'b01); complete(1, 0, 32'd5, 0, 0, 1);

        // Timeout: no strobe for 100 WAIT cycles, zero divisor also flagged.
        start(32'd9, 32'd0, 2'b00);
        early = 0;
        repeat (99) begin @(negedge clk); early |= rsp_valid; end
        chk("to_not_early", early, 0);
        @(negedge clk);
        chk("to_valid", rsp_valid, 1);
        chk("to_flag", rsp_timeout, 1);
        chk("to_data", rsp_data, 0);
        chk("to_zero", rsp_zero, 1);
        chk("to_neg", rsp_negative, 0);
        chk("to_dz", rsp_dz, 1);
        respond(0, 32'd0);

        // Strobe on the terminal cycle wins over the timeout.
        start(32'd40, 32'd3, 2'b00);
        repeat (99) @(negedge clk);
        chk("term_not_early", rsp_valid, 0);
        div_c = 32'h1234; div_is_zero = 0; div_is_negative = 0; div_available = 1;
        @(negedge clk);
        div_available = 0;
        chk("term_valid", rsp_valid, 1);
        chk("term_timeout", rsp_timeout, 0);
        chk("term_data", rsp_data, 32'h1234);
        chk("term_dz", rsp_dz, 0);
        respond(0, 32'h1234);

        start(32'd100, 32'd7, 2'b00); complete(2, 10, 32'd14, 0, 0, 0);

        // Reset mid-WAIT abandons the operation; a late strobe is ignored.
        start(32'd77, 32'd7, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_div_a", div_a, 0);
        chk("mid_rst_div_b", div_b, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        div_c = 32'd11; div_is_zero = 0; div_available = 1;
        @(negedge clk);
        div_available = 0;
        chk("late_avail_valid", rsp_valid, 0);
        chk("late_avail_busy", busy, 0);
        start(32'd77, 32'd7, 2'b01); complete(1, 0, 32'd0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
